// File: rtl/ac_cfg_sequencer_if.sv
// ac_cfg_sequencer_if: Avalon-MM master link from the codec sequencer to the i2cMaster slave port and its irq
interface ac_cfg_sequencer_if;
  logic [1:0] avmAdr;
  logic       avmWr;
  logic [7:0] avmWrData;
  logic       avmRd;
  logic [7:0] avmRdData;
  logic       irq;
  modport master(output avmAdr, avmWr, avmWrData, avmRd, input avmRdData, irq);
  modport slave(input avmAdr, avmWr, avmWrData, avmRd, output avmRdData, irq);
endinterface

// File: rtl/ac_cfg_sequencer.sv
// ac_cfg_sequencer: boot-time SSM2603/WM8731 register loader over i2c; define AC_CFG_RETRY_EN to retry a faulted register up to MAX_RETRY times
module ac_cfg_sequencer #(
  parameter int         POWERUP_CYCLES = 1_000_000,
  parameter logic [6:0] DEV_ADDR       = 7'h1A,
  parameter int         TIMEOUT_CYCLES = 100_000,
  parameter int         MAX_RETRY      = 3
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  ac_cfg_sequencer_if.master  bus,
  output logic                cfgBusy,
  output logic                cfgDone,
  output logic                cfgErr,
  output logic [3:0]          cfgIdx,
  output logic                muteN
);
  localparam int PW = $clog2(POWERUP_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PWR_LAST = PW'(POWERUP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] IDLE = 4'd0, PWR_WAIT = 4'd1, TX = 4'd2, CMD = 4'd3, WAIT_IRQ = 4'd4,
                         RD_ST = 4'd5, CHECK = 4'd6, DONE = 4'd7, ERROR = 4'd8;
  logic [3:0]    state;
  logic [PW-1:0] pwrCnt;
  logic [TW-1:0] tmoCnt;
  logic [1:0]    byteSel;
  logic [15:0]   entry;
  logic [7:0]    txByte;
  logic          nack, fault, regDone, restart, retryOk, unusedBits;
  assign nack       = bus.avmRdData[1];
  assign unusedBits = ^{bus.avmRdData[7:2], bus.avmRdData[0]};
  assign regDone    = state == CHECK && !nack && byteSel == 2'd2;
  assign restart    = (state == DONE || state == ERROR) && start;
  // the wait counter already counts the CMD cycle, so the last allowed wait ends TIMEOUT_CYCLES after the command strobe
  assign fault      = (state == WAIT_IRQ && !bus.irq && tmoCnt == TMO_LAST) || (state == CHECK && nack);
`ifdef AC_CFG_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retryCnt;
  assign retryOk = retryCnt != RW'(MAX_RETRY);
  // retry budget per register, refilled whenever a register completes or the table restarts
  always_ff @(posedge clk)
    if (reset || restart || regDone) retryCnt <= '0;
    else if (fault && retryOk) retryCnt <= retryCnt + 1'b1;
`else
  assign retryOk = 1'b0;
`endif
  // codec register table: {reg[6:0], data[8:0]}
  always_comb begin
    case (cfgIdx)
      4'd0:    entry = {7'd15, 9'h000};
      4'd1:    entry = {7'd6,  9'h010};
      4'd2:    entry = {7'd0,  9'h017};
      4'd3:    entry = {7'd1,  9'h017};
      4'd4:    entry = {7'd2,  9'h079};
      4'd5:    entry = {7'd3,  9'h079};
      4'd6:    entry = {7'd4,  9'h012};
      4'd7:    entry = {7'd5,  9'h000};
      4'd8:    entry = {7'd7,  9'h009};
      4'd9:    entry = {7'd8,  9'h000};
      4'd10:   entry = {7'd9,  9'h001};
      4'd11:   entry = {7'd6,  9'h000};
      default: entry = '0;
    endcase
  end
  assign txByte        = byteSel == 2'd0 ? {DEV_ADDR, 1'b0} : byteSel == 2'd1 ? entry[15:8] : entry[7:0];
  assign bus.avmWr     = state == TX || state == CMD;
  assign bus.avmRd     = state == RD_ST;
  assign bus.avmAdr    = state == CMD ? 2'd1 : state == RD_ST ? 2'd2 : 2'd0;
  assign bus.avmWrData = state == TX ? txByte : state == CMD ? {5'd0, 1'b1, byteSel == 2'd2, byteSel == 2'd0} : 8'd0;
  assign cfgBusy       = state inside {PWR_WAIT, TX, CMD, WAIT_IRQ, RD_ST, CHECK};
  assign cfgDone       = state == DONE;
  assign cfgErr        = state == ERROR;
  assign muteN         = state == DONE;
  // sequencer: power-up wait, then TX/CMD/WAIT_IRQ/RD_ST/CHECK per byte, three bytes per register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pwrCnt  <= '0;
      tmoCnt  <= '0;
      byteSel <= '0;
      cfgIdx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state  <= PWR_WAIT;
          pwrCnt <= '0;
        end
        PWR_WAIT: begin
          state   <= pwrCnt == PWR_LAST ? TX : PWR_WAIT;
          pwrCnt  <= pwrCnt == PWR_LAST ? pwrCnt : pwrCnt + 1'b1;
          byteSel <= '0;
        end
        TX: state <= CMD;
        CMD: begin
          state  <= WAIT_IRQ;
          tmoCnt <= TW'(1);
        end
        WAIT_IRQ: begin
          state  <= bus.irq ? RD_ST : WAIT_IRQ;
          tmoCnt <= tmoCnt == TMO_LAST ? tmoCnt : tmoCnt + 1'b1;
        end
        RD_ST: state <= CHECK;
        CHECK: begin
          if (!nack && byteSel != 2'd2) begin
            byteSel <= byteSel + 1'b1;
            state   <= TX;
          end else if (regDone) begin
            byteSel <= '0;
            cfgIdx  <= cfgIdx == 4'd11 ? cfgIdx : cfgIdx + 1'b1;
            state   <= cfgIdx == 4'd11 ? DONE : TX;
          end
        end
        DONE, ERROR: if (start) begin
          state   <= TX;
          cfgIdx  <= '0;
          byteSel <= '0;
        end
        default: state <= IDLE;
      endcase
      if (fault) begin
        state   <= retryOk ? TX : ERROR;
        byteSel <= retryOk ? 2'd0 : byteSel;
      end
    end
  end
endmodule

// File: tb/tb_ac_cfg_sequencer.sv
// tb_ac_cfg_sequencer: scoreboard bench with a randomized i2cMaster slave model for ac_cfg_sequencer
module tb_ac_cfg_sequencer;
  localparam int PWR = 16, TMO = 50, MAXR = 3;
  localparam logic [6:0] DEV = 7'h1A;
  logic clk = 0, reset = 1, start = 0;
  logic cfgBusy, cfgDone, cfgErr, muteN;
  logic [3:0] cfgIdx;
  ac_cfg_sequencer_if bus();
  ac_cfg_sequencer #(.POWERUP_CYCLES(PWR), .DEV_ADDR(DEV), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .cfgBusy(cfgBusy), .cfgDone(cfgDone), .cfgErr(cfgErr), .cfgIdx(cfgIdx), .muteN(muteN));
  always #5 clk = ~clk;
  int nChecks = 0, nFail = 0, cyc = 0, txCnt = 0;
  int regNum[12]  = '{15, 6, 0, 1, 2, 3, 4, 5, 7, 8, 9, 6};
  int regData[12] = '{'h000, 'h010, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h009, 'h000, 'h001, 'h000};
  int cmdVal[3]   = '{'h05, 'h04, 'h06};
  int expQ[$];
  bit silent = 0, noise = 0, nackNow = 0;
  int nackAt = -1, cmdNum = 0, pend = 0;
  always @(posedge clk) cyc++;
  task automatic check(string name, int act, int exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic int txVal(int i, int b);
    return b == 0 ? int'(DEV) * 2 : b == 1 ? regNum[i] * 2 + regData[i] / 256 : regData[i] % 256;
  endfunction
  task automatic pushByte(int i, int b);
    expQ.push_back(txVal(i, b));
    expQ.push_back(256 + cmdVal[b]);
  endtask
  task automatic pushRun(int nackFlat);
    for (int f = 0; f < 36; f++) begin
      pushByte(f / 3, f % 3);
      if (f == nackFlat) begin
`ifdef AC_CFG_RETRY_EN
        nackFlat = -1;
        f = (f / 3) * 3 - 1;
`else
        break;
`endif
      end
    end
  endtask
  // slave model: irq a random number of cycles after each command, optional NACK / silence / noise
  initial begin
    bus.irq = 0;
    bus.avmRdData = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.irq = 0;
        pend = 0;
      end else begin
        if (bus.avmWr && bus.avmAdr == 2'd1) begin
          bus.irq = 0;
          nackNow = cmdNum == nackAt;
          cmdNum++;
          pend = silent ? 0 : int'($urandom_range(1, 12));
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) bus.irq = 1;
        end else if (noise) bus.irq = 1'($urandom_range(0, 1));
        if (bus.avmRd) begin
          bus.avmRdData = {6'd0, nackNow, 1'b0};
          bus.irq = 0;
        end
      end
    end
  end
  // monitor: every write strobe is popped against the scoreboard
  always @(negedge clk) if (!reset) begin
    if (bus.avmWr || bus.avmRd) check("strobe_exclusive", int'(bus.avmWr & bus.avmRd), 0);
    if (bus.avmWr) begin
      if (bus.avmAdr == 2'd0) txCnt++;
      if (expQ.size() == 0) check("unexpected_write", int'({bus.avmAdr, bus.avmWrData}), -1);
      else check("write", int'({bus.avmAdr, bus.avmWrData}), expQ.pop_front());
    end
  end
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic waitEnd(int budget);
    int n = 0;
    while (!(cfgDone || cfgErr) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sequence_finished", int'(cfgDone | cfgErr), 1);
  endtask
  task automatic waitIdx5();
    int n = 0;
    while (cfgIdx != 4'd5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx5", int'(cfgIdx), 5);
  endtask
  task automatic releaseReset();
    int n = 0;
    reset = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_reset", int'(cfgBusy), 1);
    end while (!bus.avmWr && n < 100);
    check("powerup_latency", n, PWR + 1);
  endtask
  task automatic pulseStart();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    check("restart_tx", int'({bus.avmWr, bus.avmAdr, bus.avmWrData}), int'({1'b1, 2'd0, 8'h34}));
  endtask
  task automatic checkDone(int base, int expTx);
    check("cfg_done", int'(cfgDone), 1);
    check("mute_released", int'(muteN), 1);
    check("no_err", int'(cfgErr), 0);
    check("not_busy", int'(cfgBusy), 0);
    check("last_idx", int'(cfgIdx), 11);
    check("queue_drained", expQ.size(), 0);
    check("tx_count", txCnt - base, expTx);
  endtask
  initial begin
    int base, t0, n;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({cfgBusy, cfgDone, cfgErr, cfgIdx, muteN, bus.avmWr, bus.avmRd, bus.avmAdr, bus.avmWrData}), 0);
    // full table after power-up, with irq noise during the wait
    pushRun(-1);
    cmdNum = 0;
    base = txCnt;
    noise = 1;
    releaseReset();
    noise = 0;
    waitEnd(4000);
    checkDone(base, 36);
    // restart from DONE; start mid-sequence must be ignored
    pushRun(-1);
    cmdNum = 0;
    base = txCnt;
    pulseStart();
    waitIdx5();
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_ignored_busy", int'(cfgBusy), 1);
    check("start_ignored_idx", int'(cfgIdx), 5);
    waitEnd(4000);
    checkDone(base, 36);
    // NACK on byte1 of index 8
    nackAt = 25;
    pushRun(25);
    cmdNum = 0;
    base = txCnt;
    pulseStart();
    waitEnd(4000);
`ifdef AC_CFG_RETRY_EN
    checkDone(base, 39);
`else
    check("nack_err", int'(cfgErr), 1);
    check("nack_idx", int'(cfgIdx), 8);
    check("nack_muted", int'(muteN), 0);
    check("nack_not_done", int'(cfgDone), 0);
    repeat (40) @(negedge clk);
    check("nack_queue_drained", expQ.size(), 0);
    check("nack_tx_count", txCnt - base, 26);
`endif
    nackAt = -1;
    // slave never raises irq
    silent = 1;
`ifdef AC_CFG_RETRY_EN
    for (int r = 0; r <= MAXR; r++) pushByte(0, 0);
`else
    pushByte(0, 0);
`endif
    cmdNum = 0;
    pulseStart();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.avmWr && bus.avmAdr == 2'd1) && n < 10);
    t0 = cyc;
    waitEnd(2000);
    check("timeout_err", int'(cfgErr), 1);
`ifdef AC_CFG_RETRY_EN
    check("timeout_latency", cyc - t0, MAXR * (TMO + 1) + TMO);
`else
    check("timeout_latency", cyc - t0, TMO);
`endif
    check("timeout_idx", int'(cfgIdx), 0);
    silent = 0;
    pushRun(-1);
    cmdNum = 0;
    base = txCnt;
    pulseStart();
    waitEnd(4000);
    checkDone(base, 36);
    // reset at index 5 repeats the full power-up wait
    pushRun(-1);
    cmdNum = 0;
    pulseStart();
    waitIdx5();
    reset = 1;
    @(negedge clk);
    check("midreset_outputs", int'({cfgBusy, cfgDone, cfgErr, cfgIdx, muteN, bus.avmWr, bus.avmRd, bus.avmAdr, bus.avmWrData}), 0);
    expQ.delete();
    pushRun(-1);
    cmdNum = 0;
    base = txCnt;
    releaseReset();
    waitEnd(4000);
    checkDone(base, 36);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
